// File: rtl/vmul_seq_if.sv
// Handshake bundle between the issue stage, the sequencing controller and the multiplier core.
// The controller uses the slave view; the issue/core side uses the master view.
interface vmul_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  opcode;
   logic [1:0]  precision;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        mul_start;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [1:0]  mul_precision;
   logic        mul_done;
   logic [63:0] mul_product;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        err;

   modport slave (
      input  in_valid, opcode, precision, operand_a, operand_b,
      input  mul_done, mul_product, out_ready,
      output in_ready, mul_start, mul_a, mul_b, mul_precision,
      output out_valid, result, err
   );

   modport master (
      output in_valid, opcode, precision, operand_a, operand_b,
      output mul_done, mul_product, out_ready,
      input  in_ready, mul_start, mul_a, mul_b, mul_precision,
      input  out_valid, result, err
   );
endinterface

// File: rtl/vmul_seq_ctrl.sv
// Sequencing controller for the vector Vedic multiplier: operand magnitude conversion,
// core start/done handshake with timeout, per-lane sign fix-up and half selection.

module tc_sel_control_logic (
   input  logic [31:0] operand,
   input  logic [1:0]  precision,
   input  logic [1:0]  opcode,
   input  logic        operand_select,
   output logic [31:0] magnitude,
   output logic [3:0]  sign_signal
);
   logic is_signed;

   // mulhu treats both operands as unsigned, mulhsu only B
   assign is_signed = (opcode == 2'b00) || (opcode == 2'b01) ||
                      ((opcode == 2'b11) && !operand_select);

   always_comb begin
      magnitude   = operand;
      sign_signal = '0;
      case (precision)
         2'b01: begin
            for (int j = 0; j < 2; j++) begin
               if (is_signed && operand[16*j+15]) begin
                  magnitude[16*j +: 16] = 16'd0 - operand[16*j +: 16];
                  sign_signal[2*j]      = 1'b1;
                  sign_signal[2*j+1]    = 1'b1;
               end
            end
         end
         2'b10: begin
            if (is_signed && operand[31]) begin
               magnitude   = 32'd0 - operand;
               sign_signal = 4'hf;
            end
         end
         default: begin
            for (int i = 0; i < 4; i++) begin
               if (is_signed && operand[8*i+7]) begin
                  magnitude[8*i +: 8] = 8'd0 - operand[8*i +: 8];
                  sign_signal[i]      = 1'b1;
               end
            end
         end
      endcase
   end
endmodule

// state | meaning
// IDLE  | ready for a request (in_ready=1)
// TC    | register operand magnitudes and lane signs
// MUL   | core launched, waiting for mul_done or timeout
// FIX   | sign-correct lane products, select halves, pack result
// DONE  | result presented until out_ready
module vmul_seq_ctrl #(
   parameter int MAX_WAIT = 64
) (
   input  logic        clk,
   input  logic        rst,
   vmul_seq_if.slave   bus
);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {IDLE, TC, MUL, FIX, DONE} state_t;

   state_t              state;
   logic [1:0]          opcode_q;
   logic [1:0]          prec_q;
   logic [31:0]         op_a_q;
   logic [31:0]         op_b_q;
   logic [3:0]          sign_a;
   logic [3:0]          sign_b;
   logic [63:0]         product_q;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                in_ready_q;
   logic                mul_start_q;
   logic [31:0]         mul_a_q;
   logic [31:0]         mul_b_q;
   logic [1:0]          mul_prec_q;
   logic                out_valid_q;
   logic [31:0]         result_q;
   logic                err_q;

   logic [31:0]         mag_a;
   logic [31:0]         mag_b;
   logic [3:0]          sgn_a;
   logic [3:0]          sgn_b;
   logic [31:0]         fix_result;
   logic                take_hi;
   logic [15:0]         p8;
   logic [31:0]         p16;
   logic [63:0]         p32;

   tc_sel_control_logic u_tc_a (
      .operand        (op_a_q),
      .precision      (prec_q),
      .opcode         (opcode_q),
      .operand_select (1'b0),
      .magnitude      (mag_a),
      .sign_signal    (sgn_a)
   );

   tc_sel_control_logic u_tc_b (
      .operand        (op_b_q),
      .precision      (prec_q),
      .opcode         (opcode_q),
      .operand_select (1'b1),
      .magnitude      (mag_b),
      .sign_signal    (sgn_b)
   );

   assign take_hi = (opcode_q != 2'b00);

   // 16-bit lane j keeps its sign in slot 2j, the 32-bit lane in slot 0
   always_comb begin
      fix_result = '0;
      p8         = '0;
      p16        = '0;
      p32        = '0;
      case (prec_q)
         2'b01: begin
            for (int j = 0; j < 2; j++) begin
               p16 = product_q[32*j +: 32];
               if (sign_a[2*j] ^ sign_b[2*j]) p16 = 32'd0 - p16;
               fix_result[16*j +: 16] = take_hi ? p16[31:16] : p16[15:0];
            end
         end
         2'b10: begin
            p32 = product_q;
            if (sign_a[0] ^ sign_b[0]) p32 = 64'd0 - p32;
            fix_result = take_hi ? p32[63:32] : p32[31:0];
         end
         default: begin
            for (int i = 0; i < 4; i++) begin
               p8 = product_q[16*i +: 16];
               if (sign_a[i] ^ sign_b[i]) p8 = 16'd0 - p8;
               fix_result[8*i +: 8] = take_hi ? p8[15:8] : p8[7:0];
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         opcode_q    <= '0;
         prec_q      <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         sign_a      <= '0;
         sign_b      <= '0;
         product_q   <= '0;
         wait_cnt    <= '0;
         in_ready_q  <= 1'b1;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_prec_q  <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  opcode_q   <= bus.opcode;
                  prec_q     <= bus.precision;
                  op_a_q     <= bus.operand_a;
                  op_b_q     <= bus.operand_b;
                  in_ready_q <= 1'b0;
                  state      <= TC;
               end
            end
            TC: begin
               mul_a_q     <= mag_a;
               mul_b_q     <= mag_b;
               mul_prec_q  <= prec_q;
               sign_a      <= sgn_a;
               sign_b      <= sgn_b;
               wait_cnt    <= '0;
               mul_start_q <= 1'b1;
               state       <= MUL;
            end
            MUL: begin
               mul_start_q <= 1'b0;
               // a done coincident with the start pulse cannot belong to this launch
               if (!mul_start_q) begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
                  if (bus.mul_done) begin
                     product_q <= bus.mul_product;
                     state     <= FIX;
                  end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                     result_q    <= '0;
                     err_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            FIX: begin
               result_q    <= fix_result;
               err_q       <= 1'b0;
               out_valid_q <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               mul_start_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.mul_start     = mul_start_q;
   assign bus.mul_a         = mul_a_q;
   assign bus.mul_b         = mul_b_q;
   assign bus.mul_precision = mul_prec_q;
   assign bus.out_valid     = out_valid_q;
   assign bus.result        = result_q;
   assign bus.err           = err_q;
endmodule

// File: tb/tb_vmul_seq_ctrl.sv
// Bench for vmul_seq_ctrl: directed cases, timeout, mid-operation reset and randomized
// requests checked against a lane-wise signed-arithmetic reference model.
module tb_vmul_seq_ctrl;
   localparam int MAX_WAIT = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vmul_seq_if bus ();

   vmul_seq_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int core_k = 1;
   bit core_en = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int lane_w(input logic [1:0] p);
      return (p == 2'b01) ? 16 : (p == 2'b10) ? 32 : 8;
   endfunction

   function automatic longint lane_val(input logic [31:0] x, input int l, input int n, input bit sgn);
      longint v;
      longint mask;
      mask = (longint'(1) << n) - 1;
      v = longint'({32'b0, x} >> (l * n)) & mask;
      if (sgn && v[n-1]) v = v - (longint'(1) << n);
      return v;
   endfunction

   function automatic logic [31:0] ref_mag(input logic [31:0] x, input logic [1:0] p, input bit sgn);
      int n;
      longint v;
      longint mask;
      logic [63:0] acc;
      n = lane_w(p);
      mask = (longint'(1) << n) - 1;
      acc = '0;
      for (int l = 0; l < 32 / n; l++) begin
         v = lane_val(x, l, n, sgn);
         if (v < 0) v = -v;
         acc = acc | (64'(v & mask) << (l * n));
      end
      return acc[31:0];
   endfunction

   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [1:0] p,
                                           input logic [31:0] a, input logic [31:0] b);
      int n;
      longint pr;
      longint s;
      longint mask;
      logic [63:0] acc;
      n = lane_w(p);
      mask = (longint'(1) << n) - 1;
      acc = '0;
      for (int l = 0; l < 32 / n; l++) begin
         pr = lane_val(a, l, n, op != 2'b10) * lane_val(b, l, n, op != 2'b10 && op != 2'b11);
         s = (op != 2'b00) ? (pr >>> n) : pr;
         acc = acc | (64'(s & mask) << (l * n));
      end
      return acc[31:0];
   endfunction

   function automatic logic [63:0] core_prod(input logic [31:0] a, input logic [31:0] b, input logic [1:0] p);
      logic [63:0] r;
      r = '0;
      case (p)
         2'b01:   for (int j = 0; j < 2; j++) r[32*j +: 32] = 32'(a[16*j +: 16]) * 32'(b[16*j +: 16]);
         2'b10:   r = 64'(a) * 64'(b);
         default: for (int i = 0; i < 4; i++) r[16*i +: 16] = 16'(a[8*i +: 8]) * 16'(b[8*i +: 8]);
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h80808080;
         1: return 32'h80008000;
         2: return 32'h80000000;
         3: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   // one full transaction; k=0 means the core never answers
   task automatic do_op(input string tag, input logic [1:0] op, input logic [1:0] p,
                        input logic [31:0] a, input logic [31:0] b, input int k, input int hold,
                        input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
      int n;
      int starts;
      int start_at;
      logic [31:0] ema;
      logic [31:0] emb;
      ema = ref_mag(a, p, op != 2'b10);
      emb = ref_mag(b, p, op != 2'b10 && op != 2'b11);
      core_k = k;
      core_en = (k > 0);
      @(negedge clk);
      chk({tag, "_in_ready_idle"}, bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.opcode = op;
      bus.precision = p;
      bus.operand_a = a;
      bus.operand_b = b;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      bus.opcode = 2'($urandom);
      bus.precision = 2'($urandom);
      chk({tag, "_in_ready_busy"}, bus.in_ready, 0);
      n = 1;
      starts = 0;
      start_at = 0;
      while (!bus.out_valid && n < 200) begin
         if (bus.mul_start) begin
            starts++;
            start_at = n;
            chk({tag, "_mul_a"}, bus.mul_a, ema);
            chk({tag, "_mul_b"}, bus.mul_b, emb);
            chk({tag, "_mul_prec"}, bus.mul_precision, p);
         end
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_starts"}, starts, 1);
      chk({tag, "_start_cycle"}, start_at, 2);
      chk({tag, "_result"}, bus.result, exp_res);
      chk({tag, "_err"}, bus.err, exp_err);
      chk({tag, "_mul_a_held"}, bus.mul_a, ema);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_bp_valid"}, bus.out_valid, 1);
         chk({tag, "_bp_result"}, bus.result, exp_res);
         chk({tag, "_bp_in_ready"}, bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_drain_valid"}, bus.out_valid, 0);
      chk({tag, "_drain_in_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      logic [1:0] op;
      logic [1:0] p;
      logic [31:0] a;
      logic [31:0] b;
      int k;
      int guard;

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.opcode = '0;
      bus.precision = '0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.mul_done = 1'b0;
      bus.mul_product = '0;
      bus.out_ready = 1'b0;

      fork
         forever begin
            logic [63:0] prod;
            @(negedge clk);
            if (core_en && bus.mul_start) begin
               prod = core_prod(bus.mul_a, bus.mul_b, bus.mul_precision);
               repeat (core_k) @(negedge clk);
               bus.mul_done = 1'b1;
               bus.mul_product = prod;
               @(negedge clk);
               bus.mul_done = 1'b0;
               bus.mul_product = {$urandom, $urandom};
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_mul_start", bus.mul_start, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_mul_a", bus.mul_a, 0);
      rst = 1'b0;

      do_op("s32_mul",  2'b00, 2'b10, 32'hFFFFFFFD, 32'h00000005, 3, 0, 32'hFFFFFFF1, 1'b0, 7);
      do_op("s32_mulh", 2'b01, 2'b10, 32'hFFFFFFFD, 32'h00000005, 3, 0, 32'hFFFFFFFF, 1'b0, 7);
      do_op("simd8",    2'b00, 2'b00, 32'h02FF8003, 32'h030280FD, 2, 0, 32'h06FE00F7, 1'b0, 6);
      do_op("mulhu",    2'b10, 2'b00, 32'h000000FF, 32'h000000FF, 1, 0, 32'h000000FE, 1'b0, 5);
      do_op("mulhsu",   2'b11, 2'b00, 32'h000000FF, 32'h000000FF, 1, 0, 32'h000000FF, 1'b0, 5);
      do_op("backpres", 2'b00, 2'b00, 32'h02FF8003, 32'h030280FD, 4, 10, 32'h06FE00F7, 1'b0, 8);
      do_op("timeout",  2'b00, 2'b10, 32'h00000007, 32'h00000009, 0, 2, 32'h00000000, 1'b1, MAX_WAIT + 3);

      @(negedge clk);
      bus.mul_done = 1'b1;
      bus.mul_product = 64'h1234_5678_9ABC_DEF0;
      @(negedge clk);
      bus.mul_done = 1'b0;
      chk("late_done_in_ready", bus.in_ready, 1);
      chk("late_done_out_valid", bus.out_valid, 0);
      chk("late_done_mul_start", bus.mul_start, 0);
      do_op("after_late", 2'b01, 2'b01, 32'h8000_7FFF, 32'h8000_FFFF, 2, 0,
            ref_res(2'b01, 2'b01, 32'h8000_7FFF, 32'h8000_FFFF), 1'b0, 6);

      // reset while waiting on the core
      core_en = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode = 2'b00;
      bus.precision = 2'b10;
      bus.operand_a = 32'h11;
      bus.operand_b = 32'h22;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mul_in_ready", bus.in_ready, 1);
      chk("rst_mul_out_valid", bus.out_valid, 0);
      chk("rst_mul_mul_start", bus.mul_start, 0);
      chk("rst_mul_mul_a", bus.mul_a, 0);

      // reset while presenting a result, with out_ready also high
      core_en = 1'b1;
      core_k = 2;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode = 2'b00;
      bus.precision = 2'b10;
      bus.operand_a = 32'h3;
      bus.operand_b = 32'h4;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      guard = 0;
      while (!bus.out_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("rst_done_reached", bus.out_valid, 1);
      rst = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b0;
      chk("rst_done_out_valid", bus.out_valid, 0);
      chk("rst_done_in_ready", bus.in_ready, 1);
      chk("rst_done_result", bus.result, 0);
      chk("rst_done_err", bus.err, 0);
      do_op("after_rst", 2'b00, 2'b10, 32'hFFFFFFFD, 32'h00000005, 3, 0, 32'hFFFFFFF1, 1'b0, 7);

      for (int t = 0; t < 40; t++) begin
         op = 2'($urandom);
         p = 2'($urandom);
         a = pick();
         b = pick();
         k = $urandom_range(1, 5);
         do_op("rand", op, p, a, b, k, $urandom_range(0, 2), ref_res(op, p, a, b), 1'b0, 4 + k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
